// File: rtl/pcpi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_arb_pkg
// Description : Shared types and constants for the PCPI coprocessor arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pcpi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam logic [6:0] PCPI_CUSTOM0_OPCODE = 7'b0001011;
    localparam logic [6:0] FPADD_FUNCT7        = 7'b0000000;

    // Width of a core index; a single core still needs one bit.
    function automatic int grant_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcpi_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_rr_picker
// Description : Combinational round-robin select; first hit after i_last.
// Revision    : 1.0 - initial release
// ============================================================================
module pcpi_rr_picker
    import pcpi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_hit,
    input  logic [GW-1:0]      i_last,
    output logic [GW-1:0]      o_grant,
    output logic               o_any_hit
);

    logic [GW-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        o_grant   = '0;
        o_any_hit = |i_hit;
        w_idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = GW'((int'(i_last) + k) % NUM_REQ);
            if (i_hit[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcpi_copro_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_copro_arbiter
// Description : Round-robin share of one multi-cycle PCPI coprocessor between
//               NUM_REQ cores. Optional watchdog: define PCPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pcpi_copro_arbiter
    import pcpi_arb_pkg::*;
#(
    parameter int         NUM_REQ        = 2,
    parameter logic [6:0] MATCH_OPCODE   = PCPI_CUSTOM0_OPCODE,
    parameter logic [6:0] MATCH_FUNCT7   = FPADD_FUNCT7,
    parameter int         TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_insn,
    input  logic [NUM_REQ*32-1:0]   req_rs1,
    input  logic [NUM_REQ*32-1:0]   req_rs2,
    output logic [NUM_REQ-1:0]      req_wr,
    output logic [NUM_REQ*32-1:0]   req_rd,
    output logic [NUM_REQ-1:0]      req_wait,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    cp_valid,
    output logic [31:0]             cp_insn,
    output logic [31:0]             cp_rs1,
    output logic [31:0]             cp_rs2,
    input  logic                    cp_wr,
    input  logic [31:0]             cp_rd,
    input  logic                    cp_wait,
    input  logic                    cp_ready
`ifdef PCPI_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_flag
`endif
);

    localparam int              c_gw        = grant_width(NUM_REQ);
    localparam logic [c_gw-1:0] c_last_init = c_gw'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_hit;
    logic [31:0]        w_insn [NUM_REQ];
    logic [31:0]        w_rs1  [NUM_REQ];
    logic [31:0]        w_rs2  [NUM_REQ];
    logic [c_gw-1:0]    w_pick;
    logic               w_any_hit;
    logic               w_abort;
    logic               w_done;
    logic               w_deliver;
    logic               w_expired;
    logic [NUM_REQ-1:0] w_ready_nxt;

    arb_state_t         r_state;
    logic [c_gw-1:0]    r_grant;
    logic [c_gw-1:0]    r_last;
    logic               r_aborted;
    logic               r_cp_valid;
    logic [31:0]        r_cp_insn;
    logic [31:0]        r_cp_rs1;
    logic [31:0]        r_cp_rs2;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] r_req_wr;
    logic [NUM_REQ-1:0] r_req_wait;
    logic [31:0]        r_req_rd [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
            assign w_insn[i] = req_insn[32*i +: 32];
            assign w_rs1[i]  = req_rs1[32*i +: 32];
            assign w_rs2[i]  = req_rs2[32*i +: 32];
            assign w_hit[i]  = req_valid[i] &&
                               (w_insn[i][6:0]   == MATCH_OPCODE) &&
                               (w_insn[i][31:25] == MATCH_FUNCT7);
            assign req_rd[32*i +: 32] = r_req_rd[i];
        end
    endgenerate

    pcpi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GW      (c_gw)
    ) u_picker (
        .i_hit     (w_hit),
        .i_last    (r_last),
        .o_grant   (w_pick),
        .o_any_hit (w_any_hit)
    );

    // Once the granted core lets go, its eventual result must be swallowed.
    assign w_abort   = r_aborted || !w_hit[r_grant];
    assign w_done    = (r_state == BUSY) && (cp_ready || w_expired);
    assign w_deliver = w_done && !w_abort;

    always_comb begin
        w_ready_nxt = '0;
        if (w_deliver) begin
            w_ready_nxt[r_grant] = 1'b1;
        end
    end

`ifdef PCPI_ARB_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

    logic [c_cnt_w-1:0] r_tmo_cnt;
    logic               r_timeout_flag;

    // A real result arriving on the expiry cycle takes precedence.
    assign w_expired = (r_state == BUSY) && !cp_ready &&
                       (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tmo_cnt      <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
            end
            if (w_expired) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    logic w_unused_tmo;

    assign w_expired    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last      <= c_last_init;
            r_aborted   <= 1'b0;
            r_cp_valid  <= 1'b0;
            r_cp_insn   <= '0;
            r_cp_rs1    <= '0;
            r_cp_rs2    <= '0;
            r_req_ready <= '0;
            r_req_wr    <= '0;
            r_req_wait  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_req_rd[i] <= '0;
            end
        end else begin
            r_req_ready <= w_ready_nxt;
            r_req_wait  <= w_hit & ~w_ready_nxt;
            r_req_wr    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_req_rd[i] <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_any_hit) begin
                        r_grant    <= w_pick;
                        r_last     <= w_pick;
                        r_aborted  <= 1'b0;
                        r_cp_valid <= 1'b1;
                        r_cp_insn  <= w_insn[w_pick];
                        r_cp_rs1   <= w_rs1[w_pick];
                        r_cp_rs2   <= w_rs2[w_pick];
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_hit[r_grant]) begin
                        r_aborted <= 1'b1;
                    end
                    if (w_done) begin
                        r_cp_valid <= 1'b0;
                        r_state    <= DRAIN;
                        if (w_deliver && cp_ready) begin
                            r_req_wr[r_grant] <= cp_wr;
                            r_req_rd[r_grant] <= cp_rd;
                        end
                    end
                end
                DRAIN: begin
                    if (!cp_ready && !cp_wait) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign req_wr    = r_req_wr;
    assign req_wait  = r_req_wait;
    assign cp_valid  = r_cp_valid;
    assign cp_insn   = r_cp_insn;
    assign cp_rs1    = r_cp_rs1;
    assign cp_rs2    = r_cp_rs2;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_copro_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcpi_copro_arbiter
// Description : Directed self-checking bench for pcpi_copro_arbiter with a
//               stub coprocessor. Timeout scenario needs PCPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcpi_copro_arbiter;

    localparam int          N        = 2;
    localparam logic [31:0] INSN_FP  = 32'h00C5_850B;
    localparam logic [31:0] INSN_BAD = 32'h0200_000B;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_insn, req_rs1, req_rs2;
    logic [N-1:0]    req_wr, req_wait, req_ready;
    logic [N*32-1:0] req_rd;
    logic            cp_valid;
    logic [31:0]     cp_insn, cp_rs1, cp_rs2;
    logic            cp_wr, cp_wait, cp_ready;
    logic [31:0]     cp_rd;
`ifdef PCPI_ARB_TIMEOUT_EN
    logic            timeout_flag;
`endif

    int checks = 0;
    int errors = 0;

    logic stub_never;
    int   stub_lat;
    int   stub_cnt;
    int   stub_hold;

    always #5 clk = ~clk;

    pcpi_copro_arbiter #(
        .NUM_REQ        (N),
        .MATCH_OPCODE   (7'b0001011),
        .MATCH_FUNCT7   (7'b0000000),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_insn  (req_insn),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_wr    (req_wr),
        .req_rd    (req_rd),
        .req_wait  (req_wait),
        .req_ready (req_ready),
        .cp_valid  (cp_valid),
        .cp_insn   (cp_insn),
        .cp_rs1    (cp_rs1),
        .cp_rs2    (cp_rs2),
        .cp_wr     (cp_wr),
        .cp_rd     (cp_rd),
        .cp_wait   (cp_wait),
        .cp_ready  (cp_ready)
`ifdef PCPI_ARB_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    // Stub coprocessor: 1.0+2.0 gives 3.0, anything else integer add; ready lasts two cycles.
    function automatic logic [31:0] stub_result(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            stub_cnt <= 0; stub_hold <= 0;
            cp_ready <= 1'b0; cp_wr <= 1'b0; cp_rd <= '0;
        end else if (stub_hold > 0) begin
            stub_hold <= stub_hold - 1;
            if (stub_hold == 1) begin
                cp_ready <= 1'b0; cp_wr <= 1'b0; cp_rd <= '0;
            end
        end else if (cp_valid && !stub_never) begin
            if (stub_cnt == stub_lat) begin
                cp_ready <= 1'b1; cp_wr <= 1'b1; cp_rd <= stub_result(cp_rs1, cp_rs2);
                stub_hold <= 2; stub_cnt <= 0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end else begin
            stub_cnt <= 0;
        end
    end

    assign cp_wait = cp_valid && !cp_ready;

    task automatic set_core(input int c, input logic v, input logic [31:0] insn,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        req_valid[c]         = v;
        req_insn[c*32 +: 32] = insn;
        req_rs1[c*32 +: 32]  = rs1;
        req_rs2[c*32 +: 32]  = rs2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; req_valid = '0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        stub_never = 1'b0; stub_lat = 2;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; req_valid = '1; req_insn = {N{INSN_FP}};
        @(negedge clk);
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (req_wait !== '0) begin errors++; $display("FAIL reset_req_wait: got %b expected 0", req_wait); end
        checks++; if (req_wr !== '0) begin errors++; $display("FAIL reset_req_wr: got %b expected 0", req_wr); end
        checks++; if (req_rd !== '0) begin errors++; $display("FAIL reset_req_rd: got %h expected 0", req_rd); end
        checks++; if (cp_valid !== 1'b0) begin errors++; $display("FAIL reset_cp_valid: got %b expected 0", cp_valid); end
        checks++; if ({cp_insn, cp_rs1, cp_rs2} !== '0) begin errors++; $display("FAIL reset_cp_bus: got %h %h %h expected 0", cp_insn, cp_rs1, cp_rs2); end
    endtask

    task automatic test_single();
        int cr, rr, pulses;
        do_reset();
        set_core(0, 1'b1, INSN_FP, 32'h3F80_0000, 32'h4000_0000);
        cr = -1; rr = -1; pulses = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (cp_valid !== 1'b1) begin errors++; $display("FAIL single_grant_latency: cp_valid %b expected 1", cp_valid); end
                checks++; if ({cp_insn, cp_rs1, cp_rs2} !== {INSN_FP, 32'h3F80_0000, 32'h4000_0000}) begin
                    errors++; $display("FAIL single_cp_operands: got %h %h %h", cp_insn, cp_rs1, cp_rs2); end
            end
            if (cp_ready && cr < 0) cr = cyc;
            if (rr > 0 && cyc == rr + 1) begin
                checks++; if (req_rd !== '0) begin errors++; $display("FAIL single_rd_cleared: got %h expected 0", req_rd); end
            end
            if (req_ready[0]) begin
                pulses++;
                if (rr < 0) begin
                    rr = cyc;
                    checks++; if (req_wr[0] !== 1'b1) begin errors++; $display("FAIL single_wr: got %b expected 1", req_wr[0]); end
                    checks++; if (req_rd[31:0] !== 32'h4040_0000) begin errors++; $display("FAIL single_rd: got %h expected 40400000", req_rd[31:0]); end
                end
                req_valid[0] = 1'b0;
            end else if (rr < 0) begin
                checks++; if (req_wait[0] !== 1'b1) begin errors++; $display("FAIL single_wait cyc %0d: got %b expected 1", cyc, req_wait[0]); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
        checks++; if (cr < 0 || rr != cr + 1) begin errors++; $display("FAIL single_result_latency: ready at %0d, cp_ready at %0d", rr, cr); end
    endtask

    task automatic test_two();
        int order[$];
        logic [31:0] rds[$];
        bit served1;
        do_reset();
        set_core(0, 1'b1, INSN_FP, 32'h3F80_0000, 32'h4000_0000);
        set_core(1, 1'b1, INSN_FP, 32'd5, 32'd7);
        served1 = 1'b0;
        for (int cyc = 1; cyc <= 80 && order.size() < 2; cyc++) begin
            @(negedge clk);
            if (!served1) begin
                checks++; if (req_wait[1] !== !req_ready[1]) begin errors++; $display("FAIL two_wait1 cyc %0d: got %b expected %b", cyc, req_wait[1], !req_ready[1]); end
            end
            if (req_ready[0]) begin
                checks++; if (req_rd[63:32] !== 32'h0) begin errors++; $display("FAIL two_rd1_idle: got %h expected 0", req_rd[63:32]); end
            end
            for (int c = 0; c < N; c++) begin
                if (req_ready[c]) begin
                    order.push_back(c); rds.push_back(req_rd[c*32 +: 32]); req_valid[c] = 1'b0;
                    if (c == 1) served1 = 1'b1;
                end
            end
        end
        checks++;
        if (order.size() != 2) begin
            errors++; $display("FAIL two_count: got %0d services expected 2", order.size());
        end else if (order[0] != 0 || order[1] != 1 || rds[0] !== 32'h4040_0000 || rds[1] !== 32'h0000_000C) begin
            errors++; $display("FAIL two_order: got %0d,%0d rd %h,%h expected 0,1 rd 40400000,0000000c", order[0], order[1], rds[0], rds[1]);
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        logic [31:0] rds[$];
        bit rearm;
        do_reset();
        set_core(0, 1'b1, INSN_FP, 32'd10, 32'd20);
        set_core(1, 1'b1, INSN_FP, 32'd100, 32'd1);
        rearm = 1'b0;
        for (int cyc = 1; cyc <= 120 && order.size() < 3; cyc++) begin
            @(negedge clk);
            if (rearm) begin
                set_core(0, 1'b1, INSN_FP, 32'd1, 32'd2);
                rearm = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
                if (req_ready[c]) begin
                    order.push_back(c); rds.push_back(req_rd[c*32 +: 32]); req_valid[c] = 1'b0;
                    if (c == 0 && order.size() == 1) rearm = 1'b1;
                end
            end
        end
        checks++;
        if (order.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d services expected 3", order.size());
        end else begin
            checks++; if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
                errors++; $display("FAIL b2b_order: got %0d,%0d,%0d expected 0,1,0", order[0], order[1], order[2]); end
            checks++; if (rds[0] !== 32'd30 || rds[1] !== 32'd101 || rds[2] !== 32'd3) begin
                errors++; $display("FAIL b2b_rd: got %0d,%0d,%0d expected 30,101,3", rds[0], rds[1], rds[2]); end
        end
    endtask

    task automatic test_no_match();
        int served0;
        do_reset();
        set_core(0, 1'b1, INSN_FP, 32'd4, 32'd4);
        set_core(1, 1'b1, INSN_BAD, 32'd9, 32'd9);
        served0 = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            checks++; if (req_wait[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
                errors++; $display("FAIL nomatch_core1 cyc %0d: wait %b ready %b expected 0 0", cyc, req_wait[1], req_ready[1]); end
            if (req_ready[0]) begin
                served0++; req_valid[0] = 1'b0;
                checks++; if (req_rd[31:0] !== 32'd8) begin errors++; $display("FAIL nomatch_rd0: got %0d expected 8", req_rd[31:0]); end
            end
        end
        checks++; if (served0 != 1) begin errors++; $display("FAIL nomatch_core0_served: got %0d expected 1", served0); end
    endtask

    task automatic test_reset_busy();
        int pulses, got;
        logic [31:0] rd0;
        do_reset();
        stub_lat = 30;
        set_core(0, 1'b1, INSN_FP, 32'h3F80_0000, 32'h4000_0000);
        @(negedge clk);
        @(negedge clk);
        checks++; if (cp_valid !== 1'b1) begin errors++; $display("FAIL rb_busy: cp_valid %b expected 1", cp_valid); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, req_wait, req_wr, cp_valid} !== '0 || req_rd !== '0 || {cp_insn, cp_rs1, cp_rs2} !== '0) begin
            errors++; $display("FAIL rb_outputs: ready %b wait %b wr %b cp_valid %b cp_insn %h", req_ready, req_wait, req_wr, cp_valid, cp_insn); end
        resetn = 1'b1; stub_lat = 2;
        pulses = 0; got = -1; rd0 = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (cp_valid !== 1'b1) begin errors++; $display("FAIL rb_regrant: cp_valid %b expected 1", cp_valid); end
            end
            if (req_ready[0]) begin
                pulses++; req_valid[0] = 1'b0;
                if (got < 0) begin got = cyc; rd0 = req_rd[31:0]; end
            end
        end
        checks++; if (pulses != 1 || rd0 !== 32'h4040_0000) begin
            errors++; $display("FAIL rb_recover: pulses %0d rd %h expected 1 40400000", pulses, rd0); end
    endtask

`ifdef PCPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy, got;
        do_reset();
        stub_never = 1'b1;
        set_core(0, 1'b1, INSN_FP, 32'd1, 32'd1);
        busy = 0; got = -1;
        for (int cyc = 1; cyc <= 60 && got < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL tmo_flag_early: got %b expected 0", timeout_flag); end
            end
            if (cp_valid) busy++;
            if (req_ready[0]) begin
                got = cyc; req_valid[0] = 1'b0;
                checks++; if (busy != 20 || cp_valid !== 1'b0) begin errors++; $display("FAIL tmo_when: busy cycles %0d cp_valid %b expected 20 0", busy, cp_valid); end
                checks++; if (req_wr[0] !== 1'b0 || req_rd[31:0] !== 32'h0) begin errors++; $display("FAIL tmo_result: wr %b rd %h expected 0 0", req_wr[0], req_rd[31:0]); end
                checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", timeout_flag); end
            end
        end
        checks++; if (got < 0) begin errors++; $display("FAIL tmo_no_ready: got none expected pulse at busy cycle 21"); end
        repeat (5) @(negedge clk);
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag_sticky: got %b expected 1", timeout_flag); end
    endtask
`endif

    initial begin
        resetn = 1'b0; req_valid = '0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        stub_never = 1'b0; stub_lat = 2;
        test_reset();
        test_single();
        test_two();
        test_back_to_back();
        test_no_match();
        test_reset_busy();
`ifdef PCPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcpi_copro_arbiter.md
Name: pcpi_copro_arbiter

Overview:
- Shares one multi-cycle PCPI coprocessor (e.g. the FP adder) between NUM_REQ PicoRV32 cores.
- Each core-side PCPI port is matched on opcode/funct7.
- Requests are granted round-robin, forwarded to the single coprocessor port, and the result is routed back.
- Holds pcpi_wait for all matching, not-yet-served cores so no core hits its PCPI timeout while queued.

Parameters:
- NUM_REQ, 2, number of requesting cores (2..8).
- MATCH_OPCODE, 7'b0001011, insn[6:0] that selects this coprocessor.
- MATCH_FUNCT7, 7'b0000000, insn[31:25] that selects this coprocessor.
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with PCPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-core pcpi_valid
- req_insn  in  NUM_REQ*32  per-core pcpi_insn (slice i = [32i+31:32i])
- req_rs1  in  NUM_REQ*32  per-core pcpi_rs1
- req_rs2  in  NUM_REQ*32  per-core pcpi_rs2
- req_wr  out  NUM_REQ  per-core pcpi_wr
- req_rd  out  NUM_REQ*32  per-core pcpi_rd
- req_wait  out  NUM_REQ  per-core pcpi_wait
- req_ready  out  NUM_REQ  per-core pcpi_ready
- cp_valid  out  1  coprocessor pcpi_valid
- cp_insn  out  32  coprocessor pcpi_insn
- cp_rs1  out  32  coprocessor pcpi_rs1
- cp_rs2  out  32  coprocessor pcpi_rs2
- cp_wr  in  1  coprocessor pcpi_wr
- cp_rd  in  32  coprocessor pcpi_rd
- cp_wait  in  1  coprocessor pcpi_wait
- cp_ready  in  1  coprocessor pcpi_ready

Behaviour:
- hit[i] = req_valid[i] && insn_i[6:0]==MATCH_OPCODE && insn_i[31:25]==MATCH_FUNCT7. Non-hit ports get all outputs 0, leaving them to other coprocessors.
- Reset: state=IDLE, grant=0, last=NUM_REQ-1, so core 0 wins the first tie.
  - All outputs 0: req_*, cp_valid, cp_insn/rs1/rs2, req_rd.
  - Reset mid-operation abandons any transaction with no ready pulse.
- req_wait[i] is registered: 1 when hit[i] and core i is not receiving req_ready this cycle. Asserted from the cycle after hit[i] rises.
- States:
  - IDLE: if any hit, pick the first hit searching from last+1 cyclically. Latch grant, set last=grant, go BUSY. No hit: stay.
  - BUSY: cp_valid=1; cp_insn/rs1/rs2 = registered copy of the granted slice, captured at the grant.
    - On the first cycle with cp_ready=1: register req_ready[grant]=1, req_wr[grant]=cp_wr, req_rd slice=cp_rd, each for exactly one cycle, then go DRAIN.
    - If hit[grant] drops while in BUSY (core aborted): keep waiting for cp_ready, discard the result (no ready pulse), go DRAIN.
  - DRAIN: cp_valid=0. Leave for IDLE once cp_ready==0 && cp_wait==0. This absorbs the coprocessor's multi-cycle ready and lets it return to its operand state.
- Latency:
  - Grant: request seen in IDLE → cp_valid one cycle later.
  - Result: cp_ready → req_ready one cycle later.
  - Minimum gap between two grants: 1 DRAIN cycle + 1 IDLE cycle.
- Simultaneous hits resolve strictly round-robin. A core re-requesting right after service goes behind all other pending hits.
- req_rd slices of non-granted cores hold 0.

Optional Feature:
- PCPI_ARB_TIMEOUT_EN defined:
  - A 10+ bit counter clears on entering BUSY and increments each BUSY cycle.
  - At TIMEOUT_CYCLES: req_ready[grant]=1, req_wr=0, req_rd=0 for one cycle, cp_valid dropped, go DRAIN.
  - A sticky timeout_flag output (1 bit) sets on expiry and clears on reset.
- Not defined: no counter, no timeout_flag port; BUSY waits indefinitely.

Decomposition:
- Package pcpi_arb_pkg:
  - state enum {IDLE, BUSY, DRAIN};
  - constants PCPI_CUSTOM0_OPCODE=7'b0001011 and FPADD_FUNCT7=7'b0000000;
  - a grant-index width function (clog2).
- Sub-module pcpi_rr_picker: combinational round-robin select (hit vector, last index → grant index, any_hit).

Test Plan:
- Single core 0: rs1=0x3F800000, rs2=0x40000000, FP adder attached → req_ready[0] pulses once, req_wr[0]=1, req_rd[0]=0x40400000; req_wait[0] high until then.
- Cores 0 and 1 request in the same cycle after reset → core 0 served first, core 1 second. Core 1's req_wait stays high throughout, with no gap exceeding 0 cycles.
- Core 0 re-requests immediately after service while core 1 is pending → core 1 is granted before core 0.
- Core 1 uses insn funct7=0000001 → no grant; req_wait[1]=0 and req_ready[1]=0 throughout.
- resetn low during BUSY → all outputs 0 next cycle and state IDLE; a fresh request completes normally, proving the DRAIN path recovers.
- With PCPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20 and a stub that never readies → req_ready pulses at cycle 21 of BUSY with req_wr=0 and timeout_flag=1.
